// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot controller.
package evm_pkg;

    localparam int         ID_W_DEF       = 5;
    localparam logic [4:0] OFFICER_ID_DEF = 5'b11111;
    localparam int         VC_W           = 8;

    typedef logic [1:0] party_idx_t;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_READY  = 3'd1;
    localparam state_t ST_ARMED  = 3'd2;
    localparam state_t ST_CAST   = 3'd3;
    localparam state_t ST_CLOSED = 3'd4;

    function automatic logic [VC_W-1:0] sat_inc(input logic [VC_W-1:0] v);
        return (v == '1) ? v : v + VC_W'(1);
    endfunction

endpackage

// File: rtl/evm_ballot_controller_if.sv
// Keypad/ID inputs and counter-side outputs of the ballot controller.
interface evm_ballot_controller_if
    import evm_pkg::*;
#(
    parameter int ID_W        = ID_W_DEF,
    parameter int NUM_PARTIES = 4
);
    logic [ID_W-1:0]        officer_id;
    logic                   officer_login;
    logic [ID_W-1:0]        voter_id;
    logic                   voter_valid;
    logic [NUM_PARTIES-1:0] push;
    logic                   close_poll;
    logic                   show_result;

    logic                   status_led;
    logic                   vote_en;
    party_idx_t             vote_party;
    logic                   dup_voter;
    logic                   invalid_press;
    logic                   timeout;
    logic                   poll_open;
    logic                   result_en;
    logic [VC_W-1:0]        voters_cast;

    modport master (
        output officer_id, officer_login, voter_id, voter_valid, push, close_poll, show_result,
        input  status_led, vote_en, vote_party, dup_voter, invalid_press, timeout,
               poll_open, result_en, voters_cast
    );

    modport slave (
        input  officer_id, officer_login, voter_id, voter_valid, push, close_poll, show_result,
        output status_led, vote_en, vote_party, dup_voter, invalid_press, timeout,
               poll_open, result_en, voters_cast
    );
endinterface

// File: rtl/evm_voter_registry.sv
// One-vote-per-ID bitmap: combinational lookup, synchronous mark, cleared on reset.
module evm_voter_registry #(
    parameter int ID_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [ID_W-1:0] i_chk_id,
    output logic            o_voted,
    input  logic            i_mark,
    input  logic [ID_W-1:0] i_mark_id
);
    logic [(1<<ID_W)-1:0] r_map;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_map <= '0;
        else if (i_mark)
            r_map[i_mark_id] <= 1'b1;
    end

    assign o_voted = r_map[i_chk_id];
endmodule

// File: rtl/evm_ballot_controller.sv
// Ballot sequencing FSM: officer login, voter validation, single-press arming,
// vote strobe to the party counters, and poll close / result display.
module evm_ballot_controller
    import evm_pkg::*;
#(
    parameter int              ID_W           = ID_W_DEF,
    parameter logic [ID_W-1:0] OFFICER_ID     = OFFICER_ID_DEF,
    parameter int              NUM_PARTIES    = 4,
    parameter int              BALLOT_TIMEOUT = 16
) (
    input logic                     i_clk,
    input logic                     i_reset,
    evm_ballot_controller_if.slave  io_bus
);
    localparam logic [7:0] TMO_LOAD = 8'(BALLOT_TIMEOUT);

    state_t          r_state;
    logic [7:0]      r_timer;
    logic [ID_W-1:0] r_id;
    party_idx_t      r_party;
    logic            r_seen_zero;
    logic [VC_W-1:0] r_voters;
    logic            r_dup;
    logic            r_inv;
    logic            r_tmo;
    logic            r_res;

    logic            w_voted;
    logic            w_id_bad;
    int              w_cnt;
    party_idx_t      w_press_idx;

    always_comb begin
        w_press_idx = '0;
        for (int i = 0; i < NUM_PARTIES; i++)
            if (io_bus.push[i]) w_press_idx = party_idx_t'(i);
        w_cnt = $countones(io_bus.push);
    end

    // ID 0 and the officer ID are never valid voters.
    assign w_id_bad = (io_bus.voter_id == '0) || (io_bus.voter_id == OFFICER_ID);

    evm_voter_registry #(.ID_W(ID_W)) u_registry (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_chk_id  (io_bus.voter_id),
        .o_voted   (w_voted),
        .i_mark    (r_state == ST_CAST),
        .i_mark_id (r_id)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_id        <= '0;
            r_party     <= '0;
            r_seen_zero <= 1'b0;
            r_voters    <= '0;
            r_dup       <= 1'b0;
            r_inv       <= 1'b0;
            r_tmo       <= 1'b0;
            r_res       <= 1'b0;
        end else begin
            r_dup <= 1'b0;
            r_inv <= 1'b0;
            r_tmo <= 1'b0;
            r_res <= (r_state == ST_CLOSED) && io_bus.show_result;
            case (r_state)
                ST_IDLE:
                    if (io_bus.officer_login && io_bus.officer_id == OFFICER_ID)
                        r_state <= ST_READY;
                ST_READY:
                    if (io_bus.close_poll) begin
                        r_state <= ST_CLOSED;
                    end else if (io_bus.voter_valid) begin
                        if (w_id_bad || w_voted) begin
                            r_dup <= 1'b1;
                        end else begin
                            r_id        <= io_bus.voter_id;
                            r_timer     <= TMO_LOAD;
                            r_seen_zero <= 1'b0;
                            r_state     <= ST_ARMED;
                        end
                    end
                ST_ARMED:
                    // Buttons must be seen released once before any press counts.
                    if (r_seen_zero && w_cnt == 1) begin
                        r_party <= w_press_idx;
                        r_state <= ST_CAST;
                    end else begin
                        if (r_seen_zero && w_cnt > 1) r_inv <= 1'b1;
                        if (io_bus.push == '0)       r_seen_zero <= 1'b1;
                        if (r_timer <= 8'd1) begin
                            r_tmo   <= 1'b1;
                            r_timer <= '0;
                            r_state <= ST_READY;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                ST_CAST: begin
                    r_voters <= sat_inc(r_voters);
                    r_state  <= ST_READY;
                end
                ST_CLOSED: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.status_led    = (r_state == ST_ARMED);
    assign io_bus.vote_en       = (r_state == ST_CAST);
    assign io_bus.vote_party    = (r_state == ST_CAST) ? r_party : '0;
    assign io_bus.dup_voter     = r_dup;
    assign io_bus.invalid_press = r_inv;
    assign io_bus.timeout       = r_tmo;
    assign io_bus.poll_open     = (r_state == ST_READY) || (r_state == ST_ARMED) ||
                                  (r_state == ST_CAST);
    assign io_bus.result_en     = r_res;
    assign io_bus.voters_cast   = r_voters;
endmodule

// File: doc/evm_ballot_controller.md
Name: evm_ballot_controller

Overview:
Control FSM that sequences the EVM vote-counting datapath: officer login, voter-ID validation against a one-vote-per-ID registry, arming the ballot for exactly one press, emitting a single-cycle vote strobe, and closing the poll for result display. Sits between the keypad/ID inputs and the party vote counters; the counters increment only on vote_en.

Parameters:
OFFICER_ID, 5'b11111, the only ID accepted at officer_login; never accepted as a voter.
ID_W, 5, voter/officer ID width; registry depth is 2**ID_W.
NUM_PARTIES, 4, number of push buttons / parties.
BALLOT_TIMEOUT, 16, cycles ARMED may wait for a valid press before aborting (1..255).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state including registry
officer_id  in  ID_W  ID presented with officer_login
officer_login  in  1  level sampled each cycle; opens poll in IDLE
voter_id  in  ID_W  voter ID, sampled when voter_valid=1
voter_valid  in  1  voter ID present this cycle
push  in  NUM_PARTIES  party buttons, bit i = party i
close_poll  in  1  request to end polling
show_result  in  1  result display request
status_led  out  1  1 while ballot ARMED
vote_en  out  1  1-cycle strobe to counters
vote_party  out  2  party index, valid with vote_en, else 0
dup_voter  out  1  1-cycle pulse: ID already voted / reserved
invalid_press  out  1  1-cycle pulse: >1 button pressed while ARMED
timeout  out  1  1-cycle pulse: ballot aborted
poll_open  out  1  1 in READY/ARMED/CAST
result_en  out  1  1 when CLOSED and show_result=1
voters_cast  out  8  accepted votes, saturates at 255

Behaviour:
- Reset (sync, high): state=IDLE, registry all-0, voters_cast=0, timer=0, every output 0. Reset asserted mid-ballot aborts with no vote_en.
- States: IDLE, READY, ARMED, CAST, CLOSED. All outputs registered.
- IDLE: officer_login=1 and officer_id==OFFICER_ID -> READY. Wrong ID: stay IDLE, no pulse. Other inputs ignored.
- READY: close_poll=1 -> CLOSED (wins over same-cycle voter_valid). Else voter_valid=1: ID==0, ID==OFFICER_ID, or registry[ID]=1 -> dup_voter pulse next cycle, stay READY; otherwise latch ID, load timer=BALLOT_TIMEOUT, -> ARMED.
- ARMED: status_led=1. A press is only accepted after push has been sampled all-zero at least once since entering ARMED (stuck-button guard). Guard satisfied and push one-hot -> latch index, -> CAST. Guard satisfied and popcount(push)>1 -> invalid_press pulse, stay ARMED, timer keeps running. Timer decrements each ARMED cycle; on reaching 0 without acceptance -> timeout pulse, -> READY, registry unchanged. close_poll and voter_valid ignored in ARMED.
- CAST (one cycle): vote_en=1, vote_party=latched index, registry[latched ID]<=1, voters_cast+1 unless 255; -> READY.
- Latency: voter_valid at cycle N -> status_led=1 at N+1; qualifying press at M -> vote_en at M+1, poll back in READY at M+2.
- CLOSED: terminal until reset; officer_login, voter_valid, push ignored; result_en = show_result (registered, 1 cycle).
- Simultaneous press accepted and timer hitting 0 in same cycle: press wins.

Decomposition:
- Shared package evm_pkg: state enum, OFFICER_ID default, party index typedef (2-bit), voters_cast width constant.
- One sub-module: evm_voter_registry (2**ID_W bitmap; combinational check port, synchronous mark port, sync clear on reset).

Test Plan:
- Login 5'b11111, voter 1, release then push=0001 -> vote_en=1 with vote_party=0 one cycle after press; voters_cast=1; status_led 1 then 0.
- Voter 1 re-presented after voting -> dup_voter pulse, no ARMED, voters_cast stays 1; voter_id 0 and 5'b11111 likewise rejected.
- Armed voter 2, push=0110 -> invalid_press, then push=0000 then 0100 -> vote_en, vote_party=2.
- Armed voter 3, no press for 16 cycles -> timeout pulse, READY, registry[3]=0; voter 3 retries and votes successfully.
- Arm with push=1000 already held -> no vote until push released and re-pressed.
- close_poll with voter_valid same cycle in READY -> CLOSED, no ARMED; show_result=1 -> result_en=1; reset mid-ARMED -> all outputs 0, no vote_en, registry cleared.
